// File: rtl/branch_pattern_table.sv
// -----------------------------------------------------------------------------
// branch_pattern_table
//   Gshare pattern history table: 2**IDX_W two-bit saturating counters indexed
//   by (PC index XOR global history). Fetch gets a zero-latency combinational
//   prediction. Resolve-stage updates go through one registered stage and are
//   written one cycle later. After reset an init sweep writes CTR_INIT into
//   every entry; ready stays low until the sweep finishes.
//
//   Optional build macro: BPT_BYPASS_EN
//     defined   - a prediction that hits the entry being written this cycle
//                 sees the new value.
//     undefined - predictions read the array only.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous active-high reset
//   pred_pc_index  in   [IDX_W] PC index of the fetch instruction
//   pred_history   in   [IDX_W] current global history
//   pred_taken     out  prediction (combinational)
//   ready          out  init sweep complete
//   upd_valid      in   resolved conditional branch this cycle
//   upd_pc_index   in   [IDX_W] PC index of the resolved branch
//   upd_history    in   [IDX_W] history used when it was predicted
//   upd_taken      in   actual outcome
// -----------------------------------------------------------------------------
module branch_pattern_table #(
    parameter int unsigned IDX_W    = 5,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] pred_pc_index,
    input  logic [IDX_W-1:0] pred_history,
    output logic             pred_taken,
    output logic             ready,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_pc_index,
    input  logic [IDX_W-1:0] upd_history,
    input  logic             upd_taken
);
    localparam int unsigned DEPTH = 2**IDX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic             taken;
    } stage_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      sweep_ptr;
    logic                  sweep_last;
    stage_t                stg;
    logic [DEPTH-1:0][1:0] ctr;
    logic [IDX_W-1:0]      pred_idx, upd_idx;
    logic [1:0]            stg_new;
    logic                  pred_bit;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign pred_idx   = pred_pc_index ^ pred_history;
    assign upd_idx    = upd_pc_index ^ upd_history;
    assign sweep_last = (sweep_ptr == IDX_W'(DEPTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (sweep_last) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign ready = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset)                 sweep_ptr <= '0;
        else if (state == ST_INIT) sweep_ptr <= sweep_ptr + IDX_W'(1);
    end

    // ---------------- update stage ----------------
    // Updates arriving during the sweep are dropped, not queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg <= '0;
        end else begin
            stg.vld   <= upd_valid && (state == ST_RUN);
            stg.idx   <= upd_idx;
            stg.taken <= upd_taken;
        end
    end

    // Read-modify-write happens in the cycle after capture, so a back-to-back
    // update to the same entry always reads the already-written value.
    assign stg_new = sat_step(ctr[stg.idx], stg.taken);

    // ---------------- table ----------------
    // Counters carry no reset; the sweep defines them. Writes are gated by
    // reset so a pending update is discarded at the reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_INIT)
                ctr[sweep_ptr] <= CTR_INIT;
            else if (stg.vld)
                ctr[stg.idx] <= stg_new;
        end
    end

    // ---------------- prediction ----------------
`ifdef BPT_BYPASS_EN
    assign pred_bit = (stg.vld && (stg.idx == pred_idx)) ? stg_new[1] : ctr[pred_idx][1];
`else
    assign pred_bit = ctr[pred_idx][1];
`endif

    assign pred_taken = ready & pred_bit;

endmodule

// File: tb/tb_branch_pattern_table.sv
module tb_branch_pattern_table;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] pred_pc_index, pred_history;
    logic       pred_taken, ready;
    logic       upd_valid;
    logic [4:0] upd_pc_index, upd_history;
    logic       upd_taken;

    int total = 0;
    int bad   = 0;

    branch_pattern_table #(.IDX_W(5), .CTR_INIT(2'b01)) dut (
        .clk           (clk),
        .reset         (reset),
        .pred_pc_index (pred_pc_index),
        .pred_history  (pred_history),
        .pred_taken    (pred_taken),
        .ready         (ready),
        .upd_valid     (upd_valid),
        .upd_pc_index  (upd_pc_index),
        .upd_history   (upd_history),
        .upd_taken     (upd_taken)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // one more unit later, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [4:0] pc, input logic [4:0] h, input logic t);
        upd_valid = v; upd_pc_index = pc; upd_history = h; upd_taken = t;
    endtask

    task automatic set_pred(input logic [4:0] pc, input logic [4:0] h);
        pred_pc_index = pc; pred_history = h;
    endtask

    task automatic do_reset();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (32) tick();
    endtask

    task automatic test_reset();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0);
        set_pred(5'd0, 5'd0);
        reset = 1'b1;
        tick(); tick();
        #1;
        total++;
        if (ready !== 1'b0 || pred_taken !== 1'b0) begin
            bad++; $display("FAIL reset_state ready=%b pred=%b want 0/0", ready, pred_taken);
        end
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_pred(5'(i), 5'd0);
            #1;
            total++;
            if (ready !== 1'b0 || pred_taken !== 1'b0) begin
                bad++; $display("FAIL sweep_cycle%0d ready=%b pred=%b want 0/0", i, ready, pred_taken);
            end
            tick();
        end
        total++;
        if (ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_32 ready=%b want 1", ready);
        end
        for (int i = 0; i < 32; i++) begin
            set_pred(5'(i), 5'd0);
            #1;
            total++;
            if (pred_taken !== 1'b0) begin
                bad++; $display("FAIL init_entry%0d pred=%b want 0", i, pred_taken);
            end
        end
    endtask

    task automatic test_saturation();
        bit [0:4] up_exp;
        bit [0:5] dn_exp;
`ifdef BPT_BYPASS_EN
        up_exp = 5'b01111;
        dn_exp = 6'b110000;
`else
        up_exp = 5'b00111;
        dn_exp = 6'b111000;
`endif
        do_reset();
        set_pred(5'd5, 5'd0);
        for (int k = 0; k < 5; k++) begin
            set_upd(k < 3, 5'd5, 5'd0, 1'b1);
            #1;
            total++;
            if (pred_taken !== up_exp[k]) begin
                bad++; $display("FAIL sat_up_c%0d pred=%b want %b", k, pred_taken, up_exp[k]);
            end
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            set_upd(k < 4, 5'd5, 5'd0, 1'b0);
            #1;
            total++;
            if (pred_taken !== dn_exp[k]) begin
                bad++; $display("FAIL sat_dn_c%0d pred=%b want %b", k, pred_taken, dn_exp[k]);
            end
            tick();
        end
        // entry 5 is 00: one taken step must leave it not-taken (00->01)
        set_upd(1'b1, 5'd5, 5'd0, 1'b1); tick();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0); tick(); tick();
        #1;
        total++;
        if (pred_taken !== 1'b0) begin
            bad++; $display("FAIL sat_floor pred=%b want 0", pred_taken);
        end
    endtask

    task automatic test_aliasing();
        do_reset();
        set_upd(1'b1, 5'd3, 5'd6, 1'b1); tick();
        set_upd(1'b1, 5'd3, 5'd6, 1'b1); tick();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0); tick(); tick();
        set_pred(5'd5, 5'd0); #1;
        total++;
        if (pred_taken !== 1'b1) begin
            bad++; $display("FAIL alias_pc5_h0 pred=%b want 1", pred_taken);
        end
        set_pred(5'd3, 5'd0); #1;
        total++;
        if (pred_taken !== 1'b0) begin
            bad++; $display("FAIL alias_pc3_h0 pred=%b want 0", pred_taken);
        end
        set_pred(5'd6, 5'd3); #1;
        total++;
        if (pred_taken !== 1'b1) begin
            bad++; $display("FAIL alias_pc6_h3 pred=%b want 1", pred_taken);
        end
        // entry 5 must be 11: one not-taken keeps it taken, a second does not
        set_upd(1'b1, 5'd5, 5'd0, 1'b0); tick();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0); tick(); tick();
        set_pred(5'd5, 5'd0); #1;
        total++;
        if (pred_taken !== 1'b1) begin
            bad++; $display("FAIL alias_strong1 pred=%b want 1", pred_taken);
        end
        set_upd(1'b1, 5'd5, 5'd0, 1'b0); tick();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0); tick(); tick();
        #1;
        total++;
        if (pred_taken !== 1'b0) begin
            bad++; $display("FAIL alias_strong2 pred=%b want 0", pred_taken);
        end
    endtask

    task automatic test_init_drop();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_upd(i == 10, 5'd10, 5'd0, 1'b1);
            tick();
        end
        set_upd(1'b0, 5'd0, 5'd0, 1'b0);
        set_pred(5'd10, 5'd0); #1;
        total++;
        if (ready !== 1'b1 || pred_taken !== 1'b0) begin
            bad++; $display("FAIL drop_ready ready=%b pred=%b want 1/0", ready, pred_taken);
        end
        // entry 10 must be exactly 01: taken -> 10 (T), then not-taken -> 01 (NT)
        set_upd(1'b1, 5'd10, 5'd0, 1'b1); tick();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0); tick(); tick();
        #1;
        total++;
        if (pred_taken !== 1'b1) begin
            bad++; $display("FAIL drop_step_up pred=%b want 1", pred_taken);
        end
        set_upd(1'b1, 5'd10, 5'd0, 1'b0); tick();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0); tick(); tick();
        #1;
        total++;
        if (pred_taken !== 1'b0) begin
            bad++; $display("FAIL drop_step_dn pred=%b want 0", pred_taken);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_upd(1'b1, 5'd7, 5'd0, 1'b1); tick();
        set_upd(1'b1, 5'd7, 5'd0, 1'b1); tick();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0); tick(); tick();
        set_pred(5'd7, 5'd0); #1;
        total++;
        if (pred_taken !== 1'b1) begin
            bad++; $display("FAIL mid_trained pred=%b want 1", pred_taken);
        end
        // update captured at this edge, then reset while it sits in the stage
        set_upd(1'b1, 5'd7, 5'd0, 1'b1); tick();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0 || pred_taken !== 1'b0) begin
            bad++; $display("FAIL mid_reset_state ready=%b pred=%b want 0/0", ready, pred_taken);
        end
        repeat (31) tick();
        #1;
        total++;
        if (ready !== 1'b0) begin
            bad++; $display("FAIL mid_sweep_len ready=%b want 0 at cycle 31", ready);
        end
        tick();
        #1;
        total++;
        if (ready !== 1'b1 || pred_taken !== 1'b0) begin
            bad++; $display("FAIL mid_resweep ready=%b pred=%b want 1/0", ready, pred_taken);
        end
        // entry 7 back to 01: a single taken step makes it predict taken
        set_upd(1'b1, 5'd7, 5'd0, 1'b1); tick();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0); tick(); tick();
        #1;
        total++;
        if (pred_taken !== 1'b1) begin
            bad++; $display("FAIL mid_entry7_01 pred=%b want 1", pred_taken);
        end
    endtask

    task automatic test_bypass();
        logic exp_c1;
`ifdef BPT_BYPASS_EN
        exp_c1 = 1'b1;
`else
        exp_c1 = 1'b0;
`endif
        do_reset();
        set_pred(5'd9, 5'd0);
        set_upd(1'b1, 5'd9, 5'd0, 1'b1); #1;
        total++;
        if (pred_taken !== 1'b0) begin
            bad++; $display("FAIL byp_c0 pred=%b want 0", pred_taken);
        end
        tick();
        set_upd(1'b0, 5'd0, 5'd0, 1'b0); #1;
        total++;
        if (pred_taken !== exp_c1) begin
            bad++; $display("FAIL byp_c1 pred=%b want %b", pred_taken, exp_c1);
        end
        set_pred(5'd8, 5'd0); #1;
        total++;
        if (pred_taken !== 1'b0) begin
            bad++; $display("FAIL byp_other_idx pred=%b want 0", pred_taken);
        end
        set_pred(5'd9, 5'd0);
        tick();
        total++;
        if (pred_taken !== 1'b1) begin
            bad++; $display("FAIL byp_c2 pred=%b want 1", pred_taken);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_upd(1'b0, 5'd0, 5'd0, 1'b0);
        set_pred(5'd0, 5'd0);
        test_reset();
        test_saturation();
        test_aliasing();
        test_init_drop();
        test_mid_reset();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_pattern_table.md
Name: branch_pattern_table

Overview:
- Gshare pattern history table fed by branch_history.
- Index is the 5-bit PC index XOR the 5-bit global history from branch_history.
- Holds 32 two-bit saturating counters and gives the fetch stage a combinational taken/not-taken prediction.
- Updated from the resolve stage through a one-deep registered write pipeline; a sweep FSM initialises the table after reset.

Parameters:
- IDX_W, 5, width of PC index, history and table index; table depth is 2**IDX_W.
- CTR_INIT, 2'b01, value written to every counter during the init sweep (weakly not-taken).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- pred_pc_index  input  IDX_W  PC index of the instruction in fetch.
- pred_history  input  IDX_W  current global history (branch_history out).
- pred_taken  output  1  prediction, combinational from the table.
- ready  output  1  high once the init sweep is complete.
- upd_valid  input  1  resolved conditional branch this cycle.
- upd_pc_index  input  IDX_W  PC index of the resolved branch.
- upd_history  input  IDX_W  history value used at prediction time, carried down the pipe.
- upd_taken  input  1  actual branch outcome.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Index computation: pred_idx = pred_pc_index ^ pred_history; upd_idx = upd_pc_index ^ upd_history. Plain XOR, no carry.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- pred_taken = ready & ctr[pred_idx][1]. Purely combinational, zero latency.
- FSM states INIT and RUN:
  - reset=1 at any edge: state<=INIT, sweep_ptr<=0, update stage reg valid<=0.
  - INIT: each cycle write CTR_INIT to ctr[sweep_ptr] and increment sweep_ptr. When sweep_ptr==2**IDX_W-1 is written, state<=RUN.
  - ready=0 and pred_taken=0 throughout INIT. upd_valid is ignored (dropped, not queued).
  - RUN: ready=1.
  - Timing: reset deasserted before edge E0, so the first sweep write happens at E0. ready rises after edge E31, i.e. 32 cycles.
- Reset values: ready=0, pred_taken=0, stage valid=0, sweep_ptr=0. Counter contents are undefined until the sweep writes them.
- Reset asserted mid-sweep or in RUN restarts the sweep from entry 0. Any pending update is discarded.
- Update pipeline (RUN only):
  - Cycle c: upd_valid=1; {upd_idx, upd_taken} captured into the stage reg at the end of c.
  - Cycle c+1: new = sat(ctr[stage_idx], stage_taken), written at the end of c+1.
  - Back-to-back updates to the same index in c and c+1: the second reads in c+2, after the first write has landed. No hazard; both apply (e.g. 01 -> 10 -> 11).
  - One update accepted per cycle, no backpressure.
- Prediction during a pending write, same index, cycle c+1: behaviour set by BPT_BYPASS_EN (see Optional Feature).
- Prediction and update to different indices in the same cycle are independent.
- Only the update stage writes the table in RUN; the sweep writes it only in INIT, so there is no write-port conflict.

Optional Feature:
- Macro: BPT_BYPASS_EN.
- Defined: in cycle c+1, if stage valid and pred_idx==stage_idx, pred_taken uses new[1] (the value being written) instead of ctr[pred_idx][1].
- Undefined: pred_taken reads the array only; the updated value becomes visible from cycle c+2.
- Update-path timing is identical in both builds.

Test Plan:
- Reset sweep: assert reset 2 cycles, release -> ready=0 for exactly 32 cycles, then 1; all 32 entries read back as 01; pred_taken=0 everywhere.
- Saturation: pc=5, hist=0, three taken updates on consecutive cycles -> counter 01->10->11->11; pred_taken=1 from the cycle after the first write. Four not-taken updates -> 11->10->01->00->00; pred_taken=0 from the cycle after the second write.
- Gshare aliasing: update pc=3, hist=6 taken twice -> entry 5 = 11. Predict pc=5, hist=0 -> pred_taken=1; pc=3, hist=0 -> 0.
- Init drop: upd_valid=1 with taken=1 during cycle 10 of the sweep -> ignored; entry reads 01 after ready.
- Mid-operation reset: after training entry 7 to 11, pulse reset 1 cycle, with an update pending in the stage -> sweep restarts, entry 7 = 01, pending update not applied.
- Bypass: with entry 9 at 01, present a taken update to idx 9 in cycle c and predict idx 9 in c+1.
  - BPT_BYPASS_EN defined: pred_taken=1 in c+1.
  - Undefined: 0 in c+1, 1 in c+2.
